offchip_link_arb: RTL and testbench
===================================

OFFCHIP_LINK_ARB -- requirements
Module: offchip_link_arb

Interface
REQ-001 SHALL have parameter CREDITS, default 8, meaning downstream nibble slots (even, 2..30).
REQ-002 SHALL have parameter MAX_BURST, default 4, meaning max consecutive bytes per grant while the other requester waits (1..15).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester byte valid.
REQ-006 SHALL have ports req0_data / req1_data  input  8  requester byte.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  byte accepted when valid&ready at a clock edge.
REQ-008 SHALL have port out_data  output  8  byte to the off-chip serializer.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_ready  input  1  serializer accepts when out_valid&out_ready.
REQ-011 SHALL have port credit_ret  input  1  one-cycle pulse, returns 2 nibble slots (one byte).
REQ-012 SHALL have port credit_cnt  output  5  current free nibble slots.
REQ-013 SHALL have port grant_id  output  1  requester currently granted (valid when busy=1).
REQ-014 SHALL have port busy  output  1  1 when FSM is in G0 or G1.
REQ-015 SHALL have port err  output  1  sticky credit-overflow flag.

Function
REQ-016 SHALL implement FSM states IDLE, G0, G1; busy=(state!=IDLE); grant_id=1 only in G1.
REQ-017 SHALL, in IDLE, go to Gx if only reqx_valid; if both valid, go to the requester not equal to last_id; stay otherwise.
REQ-018 SHALL, in Gx, switch directly to G(other) with burst_cnt cleared when reqx_valid=0 and req(other)_valid=1, or when burst_cnt==MAX_BURST and req(other)_valid=1.
REQ-019 SHALL, in Gx, return to IDLE when both valids are 0; stay in Gx when other requester idle even if burst_cnt==MAX_BURST (burst_cnt saturates).
REQ-020 SHALL drive reqx_ready = (state==Gx) && credit_cnt>=2 && (!out_valid || out_ready); req(other)_ready=0; combinational from state and inputs.
REQ-021 SHALL, on acceptance from reqx, load out_data with the byte, set out_valid=1 next cycle (latency 1), increment burst_cnt, set last_id=x.
REQ-022 SHALL hold out_data stable while out_valid=1 and out_ready=0; clear out_valid after out_valid&out_ready with no new acceptance same edge.
REQ-023 SHALL support back-to-back acceptance: drain and reload on the same edge yields 1 byte/cycle throughput.
REQ-024 SHALL subtract 2 from credit_cnt on each requester acceptance (reservation at accept, not at output).
REQ-025 SHALL add 2 to credit_cnt on credit_ret; simultaneous accept and credit_ret leaves credit_cnt unchanged.
REQ-026 SHALL, on credit_ret when credit_cnt==CREDITS with no same-edge accept, leave credit_cnt at CREDITS and set err=1 until reset.
REQ-027 SHALL stall (ready=0) with credit_cnt<2 without changing FSM state; a credit stall SHALL NOT count toward burst_cnt.
REQ-028 SHALL never let credit_cnt exceed CREDITS or underflow below 0.
REQ-029 SHALL evaluate the FSM transition after the acceptance on the same edge (the MAX_BURST-th byte is accepted, then grant switches).

Reset
REQ-030 SHALL, on rst=0 at any time including mid-transfer, immediately force state=IDLE, out_valid=0, out_data=0, credit_cnt=CREDITS, burst_cnt=0, last_id=1, err=0; a byte pending in out_data is discarded.
REQ-031 SHALL therefore grant requester 0 first when both requesters are valid in the first cycle after reset.

Verification
REQ-032 SHALL cover: both valid continuously, out_ready=1, credit_ret every cycle -> grants 0,0,0,0,1,1,1,1,0... bytes in that order, one per cycle, credit_cnt steady at 6 after first accept.
REQ-033 SHALL cover: req0 only, out_ready=1, no credit_ret -> exactly 4 bytes accepted, credit_cnt 8->6->4->2->0, req0_ready=0 thereafter; one credit_ret -> one more byte.
REQ-034 SHALL cover: out_ready=0 for 5 cycles with byte 0xA5 pending -> out_data=0xA5, out_valid=1 held, ready=0; after out_ready=1, next byte follows next cycle.
REQ-035 SHALL cover: credit_ret with credit_cnt=8 and no accept -> credit_cnt stays 8, err=1 until reset.
REQ-036 SHALL cover: rst=0 asserted asynchronously mid-burst (out_valid=1, credit_cnt=4) -> out_valid=0, credit_cnt=8, busy=0 before next clock edge.
REQ-037 SHALL cover: req1 drops valid mid-burst while req0 valid -> next edge state G0, burst_cnt=0, no idle cycle.

Source files
------------

// File: rtl/offchip_link_arb.sv
// Two-requester arbiter feeding an off-chip serializer with credit-based flow control.
// Grants alternate on contention with a per-grant burst limit; credits are reserved at accept.
module offchip_link_arb #(
  parameter int CREDITS   = 8,
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       credit_ret,
  output logic [4:0] credit_cnt,
  output logic       grant_id,
  output logic       busy,
  output logic       err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] G0   = 2'd1;
  localparam logic [1:0] G1   = 2'd2;

  localparam logic [4:0] CRED_MAX  = 5'(CREDITS);
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  logic [1:0] state_q, state_d;
  logic [3:0] burst_q, burst_d;
  logic       last_id_q, last_id_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic [4:0] credit_q, credit_d;
  logic       err_q, err_d;

  logic       can_take;
  logic       acc0, acc1, acc;
  logic [3:0] burst_acc;

  assign can_take   = (credit_q >= 5'd2) && (!out_valid_q || out_ready);
  assign req0_ready = (state_q == G0) && can_take;
  assign req1_ready = (state_q == G1) && can_take;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign acc        = acc0 || acc1;

  // Burst count including this edge's acceptance, so the limit byte still goes out before the switch.
  assign burst_acc = (acc && (burst_q != BURST_MAX)) ? burst_q + 4'd1 : burst_q;

  always_comb begin
    state_d = state_q;
    burst_d = burst_acc;
    unique case (state_q)
      IDLE: begin
        burst_d = '0;
        if (req0_valid && req1_valid) state_d = last_id_q ? G0 : G1;
        else if (req0_valid)          state_d = G0;
        else if (req1_valid)          state_d = G1;
      end
      G0: begin
        if (req1_valid && (!req0_valid || burst_acc == BURST_MAX)) begin
          state_d = G1;
          burst_d = '0;
        end else if (!req0_valid && !req1_valid) begin
          state_d = IDLE;
          burst_d = '0;
        end
      end
      G1: begin
        if (req0_valid && (!req1_valid || burst_acc == BURST_MAX)) begin
          state_d = G0;
          burst_d = '0;
        end else if (!req0_valid && !req1_valid) begin
          state_d = IDLE;
          burst_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = '0;
      end
    endcase
  end

  always_comb begin
    last_id_d   = last_id_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (acc) begin
      last_id_d   = acc1;
      out_valid_d = 1'b1;
      out_data_d  = acc1 ? req1_data : req0_data;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (acc && !credit_ret) begin
      credit_d = credit_q - 5'd2;
    end else if (!acc && credit_ret) begin
      // A return with the pool already full is a protocol error; the count clamps.
      if (credit_q >= CRED_MAX) begin
        credit_d = CRED_MAX;
        err_d    = 1'b1;
      end else begin
        credit_d = credit_q + 5'd2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      last_id_q   <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      credit_q    <= CRED_MAX;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      last_id_q   <= last_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      credit_q    <= credit_d;
      err_q       <= err_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign credit_cnt = credit_q;
  assign grant_id   = (state_q == G1);
  assign busy       = (state_q != IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_offchip_link_arb.sv
// Directed bench for offchip_link_arb: vector table plus hand sequences for
// round-robin bursting, async reset mid-burst and first grant after reset.
module tb_offchip_link_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       credit_ret = 1'b0;
  logic [4:0] credit_cnt;
  logic       grant_id, busy, err;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  offchip_link_arb #(.CREDITS(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .credit_ret(credit_ret), .credit_cnt(credit_cnt),
    .grant_id(grant_id), .busy(busy), .err(err)
  );

  typedef struct {
    logic       r0v;
    logic [7:0] r0d;
    logic       r1v;
    logic [7:0] r1d;
    logic       ordy;
    logic       cr;
    logic       e_rdy0;
    logic       e_rdy1;
    logic       e_ov;
    logic [7:0] e_od;
    logic [4:0] e_cred;
    logic       e_busy;
    logic       e_gid;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r0v, logic [7:0] r0d, logic r1v, logic [7:0] r1d,
                              logic ordy, logic cr, logic rdy0, logic rdy1,
                              logic ov, logic [7:0] od, logic [4:0] cred,
                              logic bsy, logic gid, logic er);
    vec_t v;
    v.r0v = r0v; v.r0d = r0d; v.r1v = r1v; v.r1d = r1d; v.ordy = ordy; v.cr = cr;
    v.e_rdy0 = rdy0; v.e_rdy1 = rdy1; v.e_ov = ov; v.e_od = od; v.e_cred = cred;
    v.e_busy = bsy; v.e_gid = gid; v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".ov"},   32'(out_valid),  32'd0);
    chk({tag, ".od"},   32'(out_data),   32'd0);
    chk({tag, ".cred"}, 32'(credit_cnt), 32'd8);
    chk({tag, ".busy"}, 32'(busy),       32'd0);
    chk({tag, ".err"},  32'(err),        32'd0);
  endtask

  initial begin
    // r0v r0d    r1v r1d    ordy cr | rdy0 rdy1 | ov od     cred busy gid err
    tbl.push_back(mk(1, 8'h11, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8, 1, 0, 0));
    tbl.push_back(mk(1, 8'h12, 0, 8'h00, 1, 0, 1, 0, 1, 8'h12, 6, 1, 0, 0));
    tbl.push_back(mk(1, 8'h13, 0, 8'h00, 1, 0, 1, 0, 1, 8'h13, 4, 1, 0, 0));
    tbl.push_back(mk(1, 8'h14, 0, 8'h00, 1, 0, 1, 0, 1, 8'h14, 2, 1, 0, 0));
    tbl.push_back(mk(1, 8'h15, 0, 8'h00, 1, 0, 1, 0, 1, 8'h15, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h16, 0, 8'h00, 1, 0, 0, 0, 0, 8'h15, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h16, 0, 8'h00, 1, 0, 0, 0, 0, 8'h15, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h16, 0, 8'h00, 1, 1, 0, 0, 0, 8'h15, 2, 1, 0, 0));
    tbl.push_back(mk(1, 8'h16, 0, 8'h00, 1, 0, 1, 0, 1, 8'h16, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h17, 0, 8'h00, 0, 1, 0, 0, 1, 8'h16, 2, 1, 0, 0));
    tbl.push_back(mk(1, 8'hA5, 0, 8'h00, 1, 1, 1, 0, 1, 8'hA5, 2, 1, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 8'h18, 0, 8'h00, 0, 0, 0, 0, 1, 8'hA5, 2, 1, 0, 0));
    tbl.push_back(mk(1, 8'h18, 0, 8'h00, 1, 0, 1, 0, 1, 8'h18, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 8'h18, 2, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 8'h18, 4, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 8'h18, 6, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 8'h18, 8, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 8'h18, 8, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h18, 8, 0, 0, 1));
    tbl.push_back(mk(1, 8'h20, 1, 8'h30, 1, 0, 0, 0, 0, 8'h18, 8, 1, 1, 1));
    tbl.push_back(mk(1, 8'h20, 1, 8'h30, 1, 0, 0, 1, 1, 8'h30, 6, 1, 1, 1));
    tbl.push_back(mk(1, 8'h21, 0, 8'h30, 1, 0, 0, 1, 0, 8'h30, 6, 1, 0, 1));
    tbl.push_back(mk(1, 8'h22, 1, 8'h31, 1, 0, 1, 0, 1, 8'h22, 4, 1, 0, 1));

    #2 rst = 1'b0;
    #1 chk_reset("por");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      req0_valid = tbl[i].r0v; req0_data = tbl[i].r0d;
      req1_valid = tbl[i].r1v; req1_data = tbl[i].r1d;
      out_ready  = tbl[i].ordy; credit_ret = tbl[i].cr;
      #1;
      chk($sformatf("v%0d.rdy0", i), 32'(req0_ready), 32'(tbl[i].e_rdy0));
      chk($sformatf("v%0d.rdy1", i), 32'(req1_ready), 32'(tbl[i].e_rdy1));
      @(posedge clk); #1;
      chk($sformatf("v%0d.ov", i),   32'(out_valid),  32'(tbl[i].e_ov));
      chk($sformatf("v%0d.od", i),   32'(out_data),   32'(tbl[i].e_od));
      chk($sformatf("v%0d.cred", i), 32'(credit_cnt), 32'(tbl[i].e_cred));
      chk($sformatf("v%0d.busy", i), 32'(busy),       32'(tbl[i].e_busy));
      chk($sformatf("v%0d.gid", i),  32'(grant_id),   32'(tbl[i].e_gid));
      chk($sformatf("v%0d.err", i),  32'(err),        32'(tbl[i].e_err));
    end

    // Round-robin bursts with a credit returned every cycle after the first accept.
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; credit_ret = 1'b0; out_ready = 1'b1;
    rst = 1'b0;
    #1 chk_reset("rst2");
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h00;
    req1_valid = 1'b1; req1_data = 8'h80;
    @(posedge clk); #1;
    chk("rr.start.busy", 32'(busy), 32'd1);
    chk("rr.start.gid",  32'(grant_id), 32'd0);
    chk("rr.start.ov",   32'(out_valid), 32'd0);
    for (int k = 0; k < 12; k++) begin
      int grp;
      int idx;
      logic [7:0] exp_b;
      grp = k / 4;
      idx = k % 4;
      exp_b = 8'((grp % 2 == 0 ? 8'h00 : 8'h80) + (grp / 2) * 4 + idx);
      @(negedge clk);
      credit_ret = (k > 0);
      @(posedge clk); #1;
      chk($sformatf("rr%0d.od", k),   32'(out_data),   32'(exp_b));
      chk($sformatf("rr%0d.ov", k),   32'(out_valid),  32'd1);
      chk($sformatf("rr%0d.cred", k), 32'(credit_cnt), 32'd6);
      chk($sformatf("rr%0d.gid", k),  32'(grant_id),   32'(((k + 1) / 4) % 2));
      if (grp % 2 == 0) req0_data = req0_data + 8'd1;
      else              req1_data = req1_data + 8'd1;
    end

    // Asynchronous reset in the middle of a burst.
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; credit_ret = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h40;
    @(posedge clk);
    @(negedge clk); req0_data = 8'h41;
    @(posedge clk);
    @(negedge clk); req0_data = 8'h42;
    @(posedge clk); #1;
    chk("ar.pre.ov",   32'(out_valid),  32'd1);
    chk("ar.pre.cred", 32'(credit_cnt), 32'd4);
    #2 rst = 1'b0;
    #1;
    chk_reset("ar");

    // Both requesters valid in the first cycle after reset: requester 0 wins.
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'h55;
    req1_valid = 1'b1; req1_data = 8'h66;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("first.busy", 32'(busy),     32'd1);
    chk("first.gid",  32'(grant_id), 32'd0);
    @(posedge clk); #1;
    chk("first.od",   32'(out_data),   32'h55);
    chk("first.cred", 32'(credit_cnt), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
